// File: rtl/configuration_registers_arbiter_if.sv
// Bundle of the two requester ports and the register-bank bus shared by the arbiter.
// master is the arbiter side; slave is the requesters plus register bank.
interface configuration_registers_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_rdy;
    logic                  req0_ack;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_rdy;
    logic                  req1_ack;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  bus_rdy;
    logic                  bus_ack;

    modport master (
        input  req0_addr, req0_data, req0_rdy,
        input  req1_addr, req1_data, req1_rdy,
        input  bus_ack,
        output req0_ack, req1_ack,
        output bus_addr, bus_data, bus_rdy
    );

    modport slave (
        output req0_addr, req0_data, req0_rdy,
        output req1_addr, req1_data, req1_rdy,
        output bus_ack,
        input  req0_ack, req1_ack,
        input  bus_addr, bus_data, bus_rdy
    );
endinterface

// File: rtl/configuration_registers_arbiter.sv
// Two-requester round-robin arbiter latching one address/data write onto the register bus,
// with acknowledge routing back to the served requester and an optional stall timeout.
module configuration_registers_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    configuration_registers_arbiter_if.master bus_if,
    output logic                              grant_o,
    output logic                              busy_o,
    output logic                              timeout_err_o
);
    localparam int unsigned TimerWRaw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TimerW    = (TimerWRaw < 1) ? 1 : TimerWRaw;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRelease
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_data_q;
    logic                  bus_rdy_q;
    logic                  grant_q;
    logic                  last_q;
    logic                  timeout_err_q;
    logic [TimerW-1:0]     timer_q;
    logic                  sel;

    // A lone requester wins outright; on a tie the one not served last wins.
    assign sel = (bus_if.req0_rdy && bus_if.req1_rdy) ? ~last_q : bus_if.req1_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_rdy_q     <= 1'b0;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_if.req0_rdy || bus_if.req1_rdy) begin
                        grant_q    <= sel;
                        bus_addr_q <= sel ? bus_if.req1_addr : bus_if.req0_addr;
                        bus_data_q <= sel ? bus_if.req1_data : bus_if.req0_data;
                        bus_rdy_q  <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= StBus;
                    end
                end
                StBus: begin
                    if (bus_if.bus_ack) begin
                        bus_rdy_q <= 1'b0;
                        last_q    <= grant_q;
                        state_q   <= StRelease;
                    end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TimerLast)) begin
                        bus_rdy_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        last_q        <= grant_q;
                        state_q       <= StRelease;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TimerOne;
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_if.bus_addr = bus_addr_q;
    assign bus_if.bus_data = bus_data_q;
    assign bus_if.bus_rdy  = bus_rdy_q;
    // Acks are decoded so they pulse exactly during the release cycle.
    assign bus_if.req0_ack = (state_q == StRelease) && !grant_q;
    assign bus_if.req1_ack = (state_q == StRelease) && grant_q;
    assign grant_o         = grant_q;
    assign busy_o          = (state_q != StIdle);
    assign timeout_err_o   = timeout_err_q;
endmodule

// File: tb/tb_configuration_registers_arbiter.sv
// Directed bench: one arbiter with the default timeout and one with a 4-cycle timeout.
module tb_configuration_registers_arbiter;
    logic clk;
    logic rst_n;
    logic grant_a, busy_a, err_a;
    logic grant_b, busy_b, err_b;
    int   n_checks;
    int   n_pass;

    configuration_registers_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) ifa ();
    configuration_registers_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) ifb ();

    configuration_registers_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus_if(ifa.master),
        .grant_o(grant_a), .busy_o(busy_a), .timeout_err_o(err_a)
    );

    configuration_registers_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus_if(ifb.master),
        .grant_o(grant_b), .busy_o(busy_b), .timeout_err_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_a_all_zero(input string tag);
        check({tag, ".rdy"}, 64'(ifa.bus_rdy), 64'd0);
        check({tag, ".addr"}, ifa.bus_addr, 64'd0);
        check({tag, ".data"}, 64'(ifa.bus_data), 64'd0);
        check({tag, ".ack0"}, 64'(ifa.req0_ack), 64'd0);
        check({tag, ".ack1"}, 64'(ifa.req1_ack), 64'd0);
        check({tag, ".grant"}, 64'(grant_a), 64'd0);
        check({tag, ".busy"}, 64'(busy_a), 64'd0);
        check({tag, ".err"}, 64'(err_a), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        ifa.req0_addr = '0; ifa.req0_data = '0; ifa.req0_rdy = 1'b0;
        ifa.req1_addr = '0; ifa.req1_data = '0; ifa.req1_rdy = 1'b0;
        ifa.bus_ack   = 1'b0;
        ifb.req0_addr = '0; ifb.req0_data = '0; ifb.req0_rdy = 1'b0;
        ifb.req1_addr = '0; ifb.req1_data = '0; ifb.req1_rdy = 1'b0;
        ifb.bus_ack   = 1'b0;
        step();
        step();
        check_a_all_zero("reset");
        check("reset.b_busy", 64'(busy_b), 64'd0);
        rst_n = 1'b1;

        // Single write from requester 0, acked in the first bus cycle.
        ifa.req0_addr = 64'h0000_0000_0000_0012;
        ifa.req0_data = 32'hDEADBEEF;
        ifa.req0_rdy  = 1'b1;
        ifa.bus_ack   = 1'b1;
        step();
        check("t1.rdy", 64'(ifa.bus_rdy), 64'd1);
        check("t1.addr", ifa.bus_addr, 64'h12);
        check("t1.data", 64'(ifa.bus_data), 64'hDEADBEEF);
        check("t1.grant", 64'(grant_a), 64'd0);
        check("t1.ack0_bus", 64'(ifa.req0_ack), 64'd0);
        ifa.req0_rdy = 1'b0;
        step();
        check("t1.rdy_rel", 64'(ifa.bus_rdy), 64'd0);
        check("t1.ack0", 64'(ifa.req0_ack), 64'd1);
        check("t1.ack1", 64'(ifa.req1_ack), 64'd0);
        check("t1.busy_rel", 64'(busy_a), 64'd1);
        step();
        check("t1.ack0_idle", 64'(ifa.req0_ack), 64'd0);
        check("t1.busy_idle", 64'(busy_a), 64'd0);
        step();
        check("t1.no_regrant", 64'(ifa.bus_rdy), 64'd0);

        // Both requesters ready right after reset: grants alternate starting at 0.
        do_reset();
        ifa.req0_addr = 64'hA0A0_0000_0000_0000; ifa.req0_data = 32'h0000_00A0;
        ifa.req1_addr = 64'h0000_0000_B1B1_0001; ifa.req1_data = 32'h0000_00B1;
        ifa.req0_rdy  = 1'b1;
        ifa.req1_rdy  = 1'b1;
        ifa.bus_ack   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t2.grant%0d", i), 64'(grant_a), 64'(i % 2));
            check($sformatf("t2.addr%0d", i), ifa.bus_addr,
                  (i % 2 == 0) ? 64'hA0A0_0000_0000_0000 : 64'h0000_0000_B1B1_0001);
            step();
            check($sformatf("t2.ack0_%0d", i), 64'(ifa.req0_ack), 64'(i % 2 == 0));
            check($sformatf("t2.ack1_%0d", i), 64'(ifa.req1_ack), 64'(i % 2 == 1));
            step();
        end
        ifa.req0_rdy = 1'b0;
        ifa.req1_rdy = 1'b0;
        ifa.bus_ack  = 1'b0;
        step();

        // Bank acks after 5 bus cycles on the default-timeout instance.
        ifa.req1_addr = 64'h1234_5678_9ABC_DEF0;
        ifa.req1_data = 32'hCAFE_F00D;
        ifa.req1_rdy  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            ifa.req1_rdy  = 1'b0;
            ifa.req1_addr = 64'hFFFF_FFFF_FFFF_FFFF;
            check($sformatf("t3.rdy%0d", c), 64'(ifa.bus_rdy), 64'd1);
            check($sformatf("t3.addr%0d", c), ifa.bus_addr, 64'h1234_5678_9ABC_DEF0);
            check($sformatf("t3.data%0d", c), 64'(ifa.bus_data), 64'hCAFE_F00D);
            check($sformatf("t3.err%0d", c), 64'(err_a), 64'd0);
            if (c == 5) ifa.bus_ack = 1'b1;
        end
        step();
        ifa.bus_ack = 1'b0;
        check("t3.rdy_rel", 64'(ifa.bus_rdy), 64'd0);
        check("t3.ack1", 64'(ifa.req1_ack), 64'd1);
        check("t3.err_rel", 64'(err_a), 64'd0);
        step();

        // Timeout on the 4-cycle instance, requester 1, bank never acks.
        ifb.req1_addr = 64'h0000_0000_0000_00B4;
        ifb.req1_data = 32'h0000_0B04;
        ifb.req1_rdy  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            ifb.req1_rdy = 1'b0;
            check($sformatf("t4.rdy%0d", c), 64'(ifb.bus_rdy), 64'd1);
            check($sformatf("t4.err%0d", c), 64'(err_b), 64'd0);
        end
        step();
        check("t4.rdy_rel", 64'(ifb.bus_rdy), 64'd0);
        check("t4.err", 64'(err_b), 64'd1);
        check("t4.ack1", 64'(ifb.req1_ack), 64'd1);
        check("t4.ack0", 64'(ifb.req0_ack), 64'd0);
        step();
        check("t4.err_clr", 64'(err_b), 64'd0);
        check("t4.idle", 64'(busy_b), 64'd0);
        // Next request is served normally.
        ifb.req0_addr = 64'h0000_0000_0000_00C0;
        ifb.req0_data = 32'h0000_0C00;
        ifb.req0_rdy  = 1'b1;
        ifb.bus_ack   = 1'b1;
        step();
        ifb.req0_rdy = 1'b0;
        check("t4n.grant", 64'(grant_b), 64'd0);
        check("t4n.addr", ifb.bus_addr, 64'hC0);
        step();
        ifb.bus_ack = 1'b0;
        check("t4n.ack0", 64'(ifb.req0_ack), 64'd1);
        check("t4n.err", 64'(err_b), 64'd0);
        step();

        // Ack arrives in the 4th bus cycle, same cycle the timer expires: ack wins.
        ifb.req1_rdy = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            ifb.req1_rdy = 1'b0;
            check($sformatf("t5.rdy%0d", c), 64'(ifb.bus_rdy), 64'd1);
            if (c == 4) ifb.bus_ack = 1'b1;
        end
        step();
        ifb.bus_ack = 1'b0;
        check("t5.err", 64'(err_b), 64'd0);
        check("t5.ack1", 64'(ifb.req1_ack), 64'd1);
        check("t5.rdy_rel", 64'(ifb.bus_rdy), 64'd0);
        step();

        // Asynchronous reset in the middle of a bus cycle.
        ifa.req0_addr = 64'h0000_0000_0000_0077;
        ifa.req0_data = 32'h0000_0077;
        ifa.req0_rdy  = 1'b1;
        ifa.bus_ack   = 1'b0;
        step();
        check("t6.rdy_pre", 64'(ifa.bus_rdy), 64'd1);
        ifa.req0_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_a_all_zero("t6.async");
        step();
        check("t6.ack0_held", 64'(ifa.req0_ack), 64'd0);
        rst_n = 1'b1;
        step();
        check("t6.ack0_after", 64'(ifa.req0_ack), 64'd0);
        ifa.req1_addr = 64'h0000_0000_0000_0099;
        ifa.req1_data = 32'h0000_9999;
        ifa.req1_rdy  = 1'b1;
        ifa.bus_ack   = 1'b1;
        step();
        ifa.req1_rdy = 1'b0;
        check("t6.grant", 64'(grant_a), 64'd1);
        check("t6.addr", ifa.bus_addr, 64'h99);
        check("t6.data", 64'(ifa.bus_data), 64'h9999);
        step();
        check("t6.ack1", 64'(ifa.req1_ack), 64'd1);
        check("t6.ack0", 64'(ifa.req0_ack), 64'd0);
        ifa.bus_ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
